// File: rtl/alu_issue.sv
// alu_issue: two-stage issue front end for an external combinational ALU.
// Stage 1 decodes RV32 R/I-type ALU instructions into an ALU opcode and operands
// and holds them on alu_a/alu_b/alu_op. Stage 2 captures the ALU response with the
// tag and the illegal flag into the output registers behind a valid/ready handshake.

module alu_issue #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [31:0]      in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [7:0]       err_count
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    // Decoded view of the instruction currently offered on the input port
    logic             is_r;
    logic             is_i;
    logic [31:0]      src_b;
    logic [3:0]       dec_op;
    logic [31:0]      dec_a;
    logic [31:0]      dec_b;
    logic             dec_illegal;

    // Stage-1 bookkeeping that travels with the operands
    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_illegal;

    // Handshake terms
    logic             s2_advance;
    logic             accept;

    assign s2_advance = s1_valid && (!out_valid || out_ready);
    assign in_ready   = !s1_valid || s2_advance;
    assign accept     = in_valid && in_ready;

    // Decode opcode/funct fields into ALU opcode, operands and illegal flag
    always_comb begin
        is_r        = (in_opcode == OPC_R);
        is_i        = (in_opcode == OPC_I);
        src_b       = is_r ? in_rs2 : in_imm;
        dec_op      = 4'b0000;
        dec_a       = in_rs1;
        dec_b       = src_b;
        dec_illegal = 1'b0;

        unique case (in_funct3)
            3'b000:  dec_op = (is_r && in_funct7b5) ? 4'b1000 : 4'b0000;
            3'b001:  dec_op = 4'b0001;
            3'b010:  dec_op = 4'b0010;
            3'b011:  dec_op = 4'b0011;
            3'b100:  dec_op = 4'b0100;
            3'b101:  dec_op = in_funct7b5 ? 4'b1001 : 4'b0101;
            3'b110:  dec_op = 4'b0110;
            default: dec_op = 4'b0111;
        endcase

        // Only opcodes R and I exist here; funct7b5 is meaningful only for sub/sra/srai
        if (!is_r && !is_i) begin
            dec_illegal = 1'b1;
        end else if (is_r && in_funct7b5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101)) begin
            dec_illegal = 1'b1;
        end else if (is_i && in_funct7b5 && (in_funct3 == 3'b001)) begin
            dec_illegal = 1'b1;
        end

        // Shift amounts use only the low five bits of the second source
        if ((dec_op == 4'b0001) || (dec_op == 4'b0101) || (dec_op == 4'b1001)) begin
            dec_b = {27'b0, src_b[4:0]};
        end

        // Illegal instructions issue a harmless add of zeros
        if (dec_illegal) begin
            dec_op = 4'b0000;
            dec_a  = 32'b0;
            dec_b  = 32'b0;
        end
    end

    // Stage 1: capture decoded operation on accept, retire it when stage 2 takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_tag     <= '0;
            s1_illegal <= 1'b0;
            alu_a      <= 32'b0;
            alu_b      <= 32'b0;
            alu_op     <= 4'b0000;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_tag     <= in_tag;
            s1_illegal <= dec_illegal;
            alu_a      <= dec_a;
            alu_b      <= dec_b;
            alu_op     <= dec_op;
        end else if (s2_advance) begin
            s1_valid   <= 1'b0;
        end
    end

    // Stage 2: register the ALU response; hold while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= 32'b0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (s2_advance) begin
            out_valid   <= 1'b1;
            out_result  <= s1_illegal ? 32'b0 : alu_x;
            out_tag     <= s1_tag;
            out_illegal <= s1_illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Saturating count of accepted illegal instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (accept && dec_illegal && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors for alu_issue with a queue-based scoreboard.
// The bench supplies its own combinational ALU for the alu_a/alu_b/alu_op port.

module tb_alu_issue;

    localparam int TAG_W = 4;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_opcode;
    logic [2:0]       in_funct3;
    logic             in_funct7b5;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [31:0]      in_imm;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_op;
    logic [31:0]      alu_x;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic [7:0]       err_count;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   accepted = 0;
    int   pops     = 0;

    alu_issue #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_tag      (in_tag),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_x       (alu_x),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .err_count   (err_count)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU behaviour
    always_comb begin
        alu_x = 32'b0;
        case (alu_op)
            4'b0000: alu_x = alu_a + alu_b;
            4'b1000: alu_x = alu_a - alu_b;
            4'b0001: alu_x = alu_a << alu_b[4:0];
            4'b0010: alu_x = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'b0011: alu_x = {31'b0, alu_a < alu_b};
            4'b0100: alu_x = alu_a ^ alu_b;
            4'b0101: alu_x = alu_a >> alu_b[4:0];
            4'b1001: alu_x = 32'($signed(alu_a) >>> alu_b[4:0]);
            4'b0110: alu_x = alu_a | alu_b;
            4'b0111: alu_x = alu_a & alu_b;
            default: alu_x = 32'b0;
        endcase
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Monitor: a beat offered with out_ready high transfers at the next rising edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            pops++;
            if (sb.size() == 0) begin
                check_output("unexpected_output", {28'b0, out_tag}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = sb.pop_front();
                check_output("out_result", out_result, mon_exp.res);
                check_output("out_tag", {28'b0, out_tag}, {28'b0, mon_exp.tag});
                check_output("out_illegal", {31'b0, out_illegal}, {31'b0, mon_exp.ill});
            end
        end
    end

    // Offer one instruction and record its expected response when it is accepted
    task automatic apply_stimulus(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic [TAG_W-1:0] tag,
                                  input logic [31:0] exp_res, input logic exp_ill);
        int   waited;
        bit   done;
        exp_t e;
        in_opcode   = opc;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        in_tag      = tag;
        in_valid    = 1'b1;
        waited      = 0;
        done        = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = exp_res;
                e.tag = tag;
                e.ill = exp_ill;
                sb.push_back(e);
                accepted++;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    check_output("accept_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Wait until every expected response has been delivered
    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check_output("drain_timeout", sb.size(), 32'd0);
    endtask

    // Main directed sequence
    initial begin
        logic [31:0]      held_res;
        logic [TAG_W-1:0] held_tag;
        int               acc_base;
        int               pop_base;

        in_valid    = 1'b0;
        in_opcode   = 7'b0;
        in_funct3   = 3'b0;
        in_funct7b5 = 1'b0;
        in_rs1      = 32'b0;
        in_rs2      = 32'b0;
        in_imm      = 32'b0;
        in_tag      = '0;
        out_ready   = 1'b1;
        rst_n       = 1'b0;

        #12;
        check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("reset_err_count", {24'b0, err_count}, 32'd0);
        check_output("reset_alu_op", {28'b0, alu_op}, 32'd0);
        check_output("reset_out_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

        // Legal R/I-type operations, back to back
        apply_stimulus(OPC_R, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 4'd3, 32'd12, 1'b0);
        check_output("add_alu_op", {28'b0, alu_op}, 32'd0);
        check_output("add_alu_a", alu_a, 32'd5);
        check_output("add_alu_b", alu_b, 32'd7);
        apply_stimulus(OPC_R, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 4'd4, 32'hFFFF_FFFE, 1'b0);
        check_output("sub_alu_op", {28'b0, alu_op}, 32'd8);
        apply_stimulus(OPC_I, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0404, 4'd5, 32'hF800_0000, 1'b0);
        check_output("srai_alu_op", {28'b0, alu_op}, 32'd9);
        check_output("srai_alu_b", alu_b, 32'd4);
        apply_stimulus(OPC_R, 3'b001, 1'b0, 32'd1, 32'h0000_0023, 32'd0, 4'd6, 32'd8, 1'b0);
        check_output("sll_alu_b", alu_b, 32'd3);
        apply_stimulus(OPC_I, 3'b001, 1'b0, 32'd3, 32'd0, 32'h0000_0021, 4'd7, 32'd6, 1'b0);
        apply_stimulus(OPC_I, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd1, 4'd8, 32'd1, 1'b0);
        apply_stimulus(OPC_R, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd9, 32'd0, 1'b0);
        apply_stimulus(OPC_I, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'd0, 32'hFFFF_FFFF, 4'd10, 32'h0F0F_0F0F, 1'b0);
        apply_stimulus(OPC_R, 3'b101, 1'b0, 32'h8000_0000, 32'd31, 32'd0, 4'd11, 32'd1, 1'b0);
        apply_stimulus(OPC_I, 3'b110, 1'b0, 32'h0000_1200, 32'd0, 32'h0000_0034, 4'd12, 32'h0000_1234, 1'b0);
        apply_stimulus(OPC_R, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 4'd13, 32'h0F00_0F00, 1'b0);
        apply_stimulus(OPC_I, 3'b000, 1'b1, 32'd10, 32'd0, 32'hFFFF_FFFF, 4'd14, 32'd9, 1'b0);
        drain();

        // Illegal encodings and the saturating error counter
        check_output("err_before_illegal", {24'b0, err_count}, 32'd0);
        apply_stimulus(OPC_LD, 3'b010, 1'b0, 32'd5, 32'd7, 32'd9, 4'd1, 32'd0, 1'b1);
        check_output("err_after_first", {24'b0, err_count}, 32'd1);
        check_output("illegal_alu_a", alu_a, 32'd0);
        apply_stimulus(OPC_R, 3'b010, 1'b1, 32'd5, 32'd7, 32'd0, 4'd2, 32'd0, 1'b1);
        apply_stimulus(OPC_I, 3'b001, 1'b1, 32'd5, 32'd0, 32'd3, 4'd3, 32'd0, 1'b1);
        drain();
        check_output("err_after_three", {24'b0, err_count}, 32'd3);
        for (int i = 0; i < 297; i++) begin
            apply_stimulus(OPC_LD, 3'b000, 1'b0, 32'(i), 32'd1, 32'd1, 4'(i), 32'd0, 1'b1);
        end
        drain();
        check_output("err_saturated", {24'b0, err_count}, 32'd255);
        apply_stimulus(OPC_LD, 3'b000, 1'b0, 32'd1, 32'd1, 32'd1, 4'd0, 32'd0, 1'b1);
        drain();
        check_output("err_no_wrap", {24'b0, err_count}, 32'd255);

        // Backpressure: four ops offered while the consumer stalls
        out_ready = 1'b0;
        acc_base  = accepted;
        pop_base  = pops;
        fork
            begin
                apply_stimulus(OPC_R, 3'b000, 1'b0, 32'd100, 32'd1, 32'd0, 4'd8, 32'd101, 1'b0);
                apply_stimulus(OPC_R, 3'b000, 1'b0, 32'd200, 32'd2, 32'd0, 4'd9, 32'd202, 1'b0);
                apply_stimulus(OPC_R, 3'b000, 1'b0, 32'd300, 32'd3, 32'd0, 4'd10, 32'd303, 1'b0);
                apply_stimulus(OPC_R, 3'b000, 1'b0, 32'd400, 32'd4, 32'd0, 4'd11, 32'd404, 1'b0);
            end
        join_none
        repeat (6) @(posedge clk);
        #1;
        check_output("stall_accepted", 32'(accepted - acc_base), 32'd2);
        check_output("stall_in_ready", {31'b0, in_ready}, 32'd0);
        check_output("stall_out_valid", {31'b0, out_valid}, 32'd1);
        check_output("stall_out_result", out_result, 32'd101);
        held_res = out_result;
        held_tag = out_tag;
        repeat (3) @(posedge clk);
        #1;
        check_output("hold_result", out_result, held_res);
        check_output("hold_tag", {28'b0, out_tag}, {28'b0, held_tag});
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_output("release_pops", 32'(pops - pop_base), 32'd4);
        check_output("release_queue_empty", sb.size(), 32'd0);
        check_output("release_out_valid", {31'b0, out_valid}, 32'd0);
        wait fork;

        // Asynchronous reset with two operations in flight
        out_ready = 1'b0;
        apply_stimulus(OPC_LD, 3'b000, 1'b0, 32'd1, 32'd1, 32'd1, 4'd1, 32'd0, 1'b1);
        apply_stimulus(OPC_R, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 4'd2, 32'd3, 1'b0);
        check_output("inflight_out_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("async_err_count", {24'b0, err_count}, 32'd0);
        check_output("async_alu_op", {28'b0, alu_op}, 32'd0);
        sb.delete();
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        pop_base = pops;
        @(posedge clk);
        #1;
        check_output("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check_output("no_stale_output", 32'(pops - pop_base), 32'd0);
        check_output("no_stale_valid", {31'b0, out_valid}, 32'd0);

        // Pipeline still works after the reset
        apply_stimulus(OPC_I, 3'b000, 1'b0, 32'd40, 32'd0, 32'd2, 4'd5, 32'd42, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
